// File: rtl/mem_pkg.sv
// Shared definitions for the MIPS32 memory-access stage: size codes,
// stage state encoding and the lane helpers used when issuing an access.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is reserved and behaves as a word

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Byte enables for an access; big-endian mirrors the lane index.
  function automatic logic [3:0] be_gen(input logic [1:0] addr, input logic [1:0] size,
                                        input logic big_endian);
    logic [1:0] lane;
    lane = big_endian ? (2'd3 - addr) : addr;
    case (size)
      SZ_BYTE: be_gen = 4'b0001 << lane;
      SZ_HALF: be_gen = (addr[1] ^ big_endian) ? 4'b1100 : 4'b0011;
      default: be_gen = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane so the byte enables alone pick the target.
  function automatic logic [31:0] store_rep(input logic [31:0] data, input logic [1:0] size);
    case (size)
      SZ_BYTE: store_rep = {4{data[7:0]}};
      SZ_HALF: store_rep = {2{data[15:0]}};
      default: store_rep = data;
    endcase
  endfunction

  // Halves need an even address, words (and the reserved code) a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] addr, input logic [1:0] size);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr[0];
      default: is_misaligned = (addr != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
// Handshake: the master raises o_dm_req with o_dm_we/addr/be/wdata and holds
// all of them stable until the cycle i_dm_ack is high; that cycle completes
// the access and i_dm_rdata is valid in it. The master may abandon a request
// only through reset. Ack outside an outstanding request is ignored.
interface mem_stage_if;
  logic        o_dm_req;
  logic        o_dm_we;
  logic [31:0] o_dm_addr;
  logic [3:0]  o_dm_be;
  logic [31:0] o_dm_wdata;
  logic        i_dm_ack;
  logic [31:0] i_dm_rdata;

  modport master (
    output o_dm_req, o_dm_we, o_dm_addr, o_dm_be, o_dm_wdata,
    input  i_dm_ack, i_dm_rdata
  );

  modport slave (
    input  o_dm_req, o_dm_we, o_dm_addr, o_dm_be, o_dm_wdata,
    output i_dm_ack, i_dm_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed byte or halfword from the
// returned memory word and sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [1:0]  lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane and extend it to a full register value
  always_comb begin
    lane   = BIG_ENDIAN ? (2'd3 - i_addr) : i_addr;
    byte_v = i_rdata[{lane, 3'b000} +: 8];
    half_v = (i_addr[1] ^ BIG_ENDIAN) ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_BYTE: o_data = {{24{byte_v[7] & ~i_unsigned}}, byte_v};
      SZ_HALF: o_data = {{16{half_v[15] & ~i_unsigned}}, half_v};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory-access stage. Passes ALU results through in one cycle,
// performs loads/stores over the req/ack data-memory bus (stalling upstream
// while an access is outstanding) and registers a write-back-ready result.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic        i_flush,
  input  logic [31:0] i_busC,
  input  logic [31:0] i_busB,
  input  logic [4:0]  i_rd,
  input  logic        i_regwr,
  input  logic        i_memrd,
  input  logic        i_memwr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic        o_stall,
  mem_stage_if.master dm,
  output logic        o_valid,
  output logic [31:0] o_busW,
  output logic [4:0]  o_rd,
  output logic        o_regwr,
  output logic        o_exc_align,
  output logic        o_exc_bus,
  output logic [31:0] o_badaddr,
  output state_e      o_dbg_state
);

  // BUSY cycles are counted from 0; the last allowed one is TIMEOUT-1.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        memrd_q, memrd_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwr_q, regwr_d;
  logic        flush_q, flush_d;
  logic        valid_q, valid_d;
  logic [31:0] busw_q, busw_d;
  logic [4:0]  ord_q, ord_d;
  logic        oregwr_q, oregwr_d;
  logic        exca_q, exca_d;
  logic        excb_q, excb_d;
  logic [31:0] bad_q, bad_d;
  logic        stall_c;
  logic        accept;
  logic        memop;
  logic        discard;
  logic [31:0] load_data;

  mem_load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .i_rdata   (dm.i_dm_rdata),
    .i_addr    (addr_q[1:0]),
    .i_size    (size_q),
    .i_unsigned(uns_q),
    .o_data    (load_data)
  );

  // Next-state, bus request and write-back result selection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    memrd_d  = memrd_q;
    size_d   = size_q;
    uns_d    = uns_q;
    rd_d     = rd_q;
    regwr_d  = regwr_q;
    flush_d  = flush_q;
    valid_d  = 1'b0;
    busw_d   = busw_q;
    ord_d    = ord_q;
    oregwr_d = 1'b0;
    exca_d   = 1'b0;
    excb_d   = 1'b0;
    bad_d    = bad_q;
    stall_c  = 1'b0;
    accept   = i_valid & ~i_flush;
    memop    = i_memrd | i_memwr;
    discard  = flush_q | i_flush;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ord_d  = i_rd;
          busw_d = i_busC;
          if (!memop) begin
            valid_d  = 1'b1;
            oregwr_d = i_regwr;
          end else if (is_misaligned(i_busC[1:0], i_size)) begin
            valid_d = 1'b1;
            exca_d  = 1'b1;
            bad_d   = i_busC;
          end else begin
            stall_c = 1'b1;
            state_d = ST_BUSY;
            cnt_d   = 16'd0;
            req_d   = 1'b1;
            we_d    = i_memwr;
            addr_d  = i_busC;
            be_d    = be_gen(i_busC[1:0], i_size, BIG_ENDIAN);
            wdata_d = store_rep(i_busB, i_size);
            memrd_d = i_memrd;
            size_d  = i_size;
            uns_d   = i_unsigned;
            rd_d    = i_rd;
            regwr_d = i_regwr;
            flush_d = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        // A flush cannot retract the request; it only suppresses the result.
        stall_c = ~dm.i_dm_ack;
        flush_d = discard;
        if (dm.i_dm_ack) begin
          state_d  = ST_IDLE;
          req_d    = 1'b0;
          valid_d  = ~discard;
          ord_d    = rd_q;
          busw_d   = memrd_q ? load_data : addr_q;
          oregwr_d = memrd_q & regwr_q & ~discard;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          valid_d = ~discard;
          excb_d  = ~discard;
          ord_d   = rd_q;
          if (!discard) bad_d = addr_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request and result registers; reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      memrd_q  <= 1'b0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      rd_q     <= 5'd0;
      regwr_q  <= 1'b0;
      flush_q  <= 1'b0;
      valid_q  <= 1'b0;
      busw_q   <= 32'd0;
      ord_q    <= 5'd0;
      oregwr_q <= 1'b0;
      exca_q   <= 1'b0;
      excb_q   <= 1'b0;
      bad_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      memrd_q  <= memrd_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      rd_q     <= rd_d;
      regwr_q  <= regwr_d;
      flush_q  <= flush_d;
      valid_q  <= valid_d;
      busw_q   <= busw_d;
      ord_q    <= ord_d;
      oregwr_q <= oregwr_d;
      exca_q   <= exca_d;
      excb_q   <= excb_d;
      bad_q    <= bad_d;
    end
  end

  // Stall is combinational but held low while in reset so every output reads 0
  assign o_stall       = stall_c & rst_n;
  assign dm.o_dm_req   = req_q;
  assign dm.o_dm_we    = we_q;
  assign dm.o_dm_addr  = {addr_q[31:2], 2'b00};
  assign dm.o_dm_be    = be_q;
  assign dm.o_dm_wdata = wdata_q;
  assign o_valid       = valid_q;
  assign o_busW        = busw_q;
  assign o_rd          = ord_q;
  assign o_regwr       = oregwr_q;
  assign o_exc_align   = exca_q;
  assign o_exc_bus     = excb_q;
  assign o_badaddr     = bad_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed instruction sequences, a transaction-level
// model of the expected write-back results and memory requests, and one
// compare process that checks the DUT against it every cycle.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        i_flush;
  logic [31:0] i_busC;
  logic [31:0] i_busB;
  logic [4:0]  i_rd;
  logic        i_regwr;
  logic        i_memrd;
  logic        i_memwr;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_busW;
  logic [4:0]  o_rd;
  logic        o_regwr;
  logic        o_exc_align;
  logic        o_exc_bus;
  logic [31:0] o_badaddr;
  state_e      dbg_state;

  mem_stage_if dm_if ();

  mem_stage #(.TIMEOUT(TMO), .BIG_ENDIAN(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_flush    (i_flush),
    .i_busC     (i_busC),
    .i_busB     (i_busB),
    .i_rd       (i_rd),
    .i_regwr    (i_regwr),
    .i_memrd    (i_memrd),
    .i_memwr    (i_memwr),
    .i_size     (i_size),
    .i_unsigned (i_unsigned),
    .o_stall    (o_stall),
    .dm         (dm_if.master),
    .o_valid    (o_valid),
    .o_busW     (o_busW),
    .o_rd       (o_rd),
    .o_regwr    (o_regwr),
    .o_exc_align(o_exc_align),
    .o_exc_bus  (o_exc_bus),
    .o_badaddr  (o_badaddr),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // result: {chk_data, busw[31:0], rd[4:0], regwr, exc_align, exc_bus, badaddr[31:0]}
  logic [72:0] exp_q[$];
  // request: {we, addr[31:0], be[3:0], wdata[31:0]}
  logic [68:0] exp_req_q[$];

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [72:0] pack_res(input logic c, input logic [31:0] busw,
                                           input logic [4:0] rd, input logic regwr,
                                           input logic ea, input logic eb,
                                           input logic [31:0] bad);
    return {c, busw, rd, regwr, ea, eb, bad};
  endfunction

  function automatic bit m_misaligned(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 32'd2) != 32'd0;
    return (a % 32'd4) != 32'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    int k;
    k = int'(a % 32'd4);
    if (sz == 2'd0) return 4'(1 << k);
    if (sz == 2'd1) return (k >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] b, input logic [1:0] sz);
    if (sz == 2'd0) return (b % 32'h100) * 32'h01010101;
    if (sz == 2'd1) return (b % 32'h10000) * 32'h00010001;
    return b;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] a,
                                         input logic [1:0] sz, input logic uns);
    int k;
    logic [31:0] v;
    k = int'(a % 32'd4);
    if (sz == 2'd0) begin
      v = (rdata >> (8 * k)) % 32'h100;
      if (!uns && v >= 32'h80) v = v - 32'h100;
      return v;
    end
    if (sz == 2'd1) begin
      v = (rdata >> (16 * (k / 2))) % 32'h10000;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
      return v;
    end
    return rdata;
  endfunction

  // ---------------- compare process ----------------
  logic        prev_req;
  logic [68:0] cur_req;
  logic [72:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
      cur_req  = '0;
    end else begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 160'(o_valid), 160'(0));
        end else begin
          e = exp_q.pop_front();
          if (e[72]) begin
            chk("res_busw", 160'(o_busW), 160'(e[71:40]));
            chk("res_rd", 160'(o_rd), 160'(e[39:35]));
          end
          chk("res_regwr", 160'(o_regwr), 160'(e[34]));
          chk("res_exc", 160'({o_exc_align, o_exc_bus}), 160'(e[33:32]));
          if (e[33] || e[32]) chk("res_badaddr", 160'(o_badaddr), 160'(e[31:0]));
        end
      end else begin
        chk("exc_when_invalid", 160'({o_exc_align, o_exc_bus}), 160'(0));
      end
      if (dm_if.o_dm_req) begin
        if (!prev_req) begin
          if (exp_req_q.size() == 0) chk("unexpected_req", 160'(1), 160'(0));
          else cur_req = exp_req_q.pop_front();
        end
        chk("req_attr", 160'({dm_if.o_dm_we, dm_if.o_dm_addr, dm_if.o_dm_be}),
            160'(cur_req[68:32]));
        if (cur_req[68]) chk("req_wdata", 160'(dm_if.o_dm_wdata), 160'(cur_req[31:0]));
      end
      prev_req = dm_if.o_dm_req;
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic idle(input int n);
    i_valid = 0; i_flush = 0; i_memrd = 0; i_memwr = 0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_stall", 160'(o_stall), 160'(0));
      chk("idle_req", 160'(dm_if.o_dm_req), 160'(0));
      @(posedge clk); #1;
    end
  endtask

  task automatic alu_op(input logic [31:0] val, input logic [4:0] rd, input logic regwr);
    i_valid = 1; i_flush = 0; i_busC = val; i_busB = 0; i_rd = rd; i_regwr = regwr;
    i_memrd = 0; i_memwr = 0; i_size = 2'd2; i_unsigned = 0;
    exp_q.push_back(pack_res(1'b1, val, rd, regwr, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    chk("alu_stall", 160'(o_stall), 160'(0));
    @(posedge clk); #1;
  endtask

  // ack_at / flush_at: BUSY cycle index (0 = first BUSY cycle), -1 = never
  task automatic mem_op(input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input logic regwr, input logic is_load, input logic [1:0] sz,
                        input logic uns, input int ack_at, input logic [31:0] rdata,
                        input int flush_at);
    bit discard;
    bit tmo;
    i_valid = 1; i_flush = 0; i_busC = addr; i_busB = wd; i_rd = rd; i_regwr = regwr;
    i_memrd = is_load; i_memwr = !is_load; i_size = sz; i_unsigned = uns;
    if (m_misaligned(addr, sz)) begin
      exp_q.push_back(pack_res(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, addr));
      @(negedge clk);
      chk("mis_stall", 160'(o_stall), 160'(0));
      chk("mis_req", 160'(dm_if.o_dm_req), 160'(0));
      @(posedge clk); #1;
      chk("mis_noreq", 160'(dm_if.o_dm_req), 160'(0));
      return;
    end
    exp_req_q.push_back({!is_load, addr - addr % 32'd4, m_be(addr, sz), m_wdata(wd, sz)});
    @(negedge clk);
    chk("accept_stall", 160'(o_stall), 160'(1));
    @(posedge clk); #1;
    discard = 1'b0;
    for (int k = 0; k < 64; k++) begin
      tmo = (k != ack_at) && (k == TMO - 1);
      dm_if.i_dm_ack   = (k == ack_at);
      dm_if.i_dm_rdata = (k == ack_at) ? rdata : 32'h0;
      i_flush = (k == flush_at);
      if (k == flush_at) discard = 1'b1;
      @(negedge clk);
      chk("busy_req", 160'(dm_if.o_dm_req), 160'(1));
      chk("busy_stall", 160'(o_stall), 160'((k == ack_at) ? 1'b0 : 1'b1));
      chk("busy_bubble", 160'(o_valid), 160'(0));
      @(posedge clk); #1;
      dm_if.i_dm_ack = 1'b0;
      i_flush = 1'b0;
      if (k == ack_at || tmo) begin
        chk("req_drop", 160'(dm_if.o_dm_req), 160'(0));
        if (!discard) begin
          if (tmo) exp_q.push_back(pack_res(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, addr));
          else if (is_load)
            exp_q.push_back(pack_res(1'b1, m_load(rdata, addr, sz, uns), rd, regwr,
                                     1'b0, 1'b0, 32'd0));
          else exp_q.push_back(pack_res(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0));
        end
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; i_valid = 0; i_flush = 0; i_busC = 0; i_busB = 0; i_rd = 0; i_regwr = 0;
    i_memrd = 0; i_memwr = 0; i_size = 0; i_unsigned = 0;
    dm_if.i_dm_ack = 0; dm_if.i_dm_rdata = 0;
    #23;
    chk("reset_outputs", 160'({o_stall, dm_if.o_dm_req, dm_if.o_dm_we, dm_if.o_dm_addr,
        dm_if.o_dm_be, dm_if.o_dm_wdata, o_valid, o_busW, o_rd, o_regwr, o_exc_align,
        o_exc_bus, o_badaddr}), 160'(0));
    chk("reset_state", 160'(dbg_state == ST_IDLE), 160'(1));
    rst_n = 1;
    @(posedge clk); #1;

    // model pinned against hand-computed values
    chk("pin_lb", 160'(m_load(32'h80AABBCC, 32'h103, 2'd0, 1'b0)), 160'(32'hFFFFFF80));
    chk("pin_lbu", 160'(m_load(32'h80AABBCC, 32'h103, 2'd0, 1'b1)), 160'(32'h00000080));
    chk("pin_lh", 160'(m_load(32'h80AABBCC, 32'h102, 2'd1, 1'b0)), 160'(32'hFFFF80AA));
    chk("pin_be_b", 160'(m_be(32'h103, 2'd0)), 160'(4'b1000));
    chk("pin_be_h", 160'(m_be(32'h202, 2'd1)), 160'(4'b1100));
    chk("pin_wd_h", 160'(m_wdata(32'h0000BEEF, 2'd1)), 160'(32'hBEEFBEEF));

    idle(1);
    alu_op(32'h12345678, 5'd5, 1'b1);
    idle(1);
    // loads and stores: addr, wdata, rd, regwr, load, size, uns, ack_at, rdata, flush_at
    mem_op(32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 2'd0, 1'b0, 0, 32'h80AABBCC, -1);   // LB
    mem_op(32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 2'd0, 1'b1, 0, 32'h80AABBCC, -1);   // LBU
    mem_op(32'h202, 32'h0000BEEF, 5'd0, 1'b0, 1'b0, 2'd1, 1'b0, 3, 32'h0, -1);   // SH
    idle(1);
    mem_op(32'h301, 32'h0, 5'd9, 1'b1, 1'b1, 2'd2, 1'b0, 0, 32'h0, -1);          // LW misaligned
    mem_op(32'h101, 32'h0, 5'd9, 1'b1, 1'b1, 2'd1, 1'b0, 0, 32'h0, -1);          // LH misaligned
    mem_op(32'h22, 32'h0, 5'd9, 1'b1, 1'b1, 2'd3, 1'b0, 0, 32'h0, -1);           // reserved size
    mem_op(32'h102, 32'h0, 5'd10, 1'b1, 1'b1, 2'd1, 1'b0, 1, 32'h80AABBCC, -1);  // LH
    mem_op(32'h100, 32'h0, 5'd11, 1'b1, 1'b1, 2'd1, 1'b1, 2, 32'h1234ABCD, -1);  // LHU
    mem_op(32'h003, 32'h11223344, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 32'h0, -1);   // SB
    mem_op(32'h404, 32'h0, 5'd12, 1'b1, 1'b1, 2'd2, 1'b0, 1, 32'hCAFEF00D, -1);  // LW
    mem_op(32'h020, 32'h0, 5'd13, 1'b1, 1'b1, 2'd3, 1'b0, 0, 32'h0BADBEEF, -1);  // size 11
    // back-to-back: accept follows the completion edge directly
    mem_op(32'h010, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 2'd2, 1'b0, 0, 32'h0, -1);   // SW
    alu_op(32'h00000042, 5'd14, 1'b1);
    mem_op(32'h201, 32'h0, 5'd15, 1'b1, 1'b1, 2'd0, 1'b0, 0, 32'h00007F00, -1);  // LB 0x7F
    idle(1);
    // timeout, then ack coinciding with the last BUSY cycle
    mem_op(32'h500, 32'h0, 5'd16, 1'b1, 1'b1, 2'd2, 1'b0, -1, 32'h0, -1);
    mem_op(32'h504, 32'h0, 5'd17, 1'b1, 1'b1, 2'd2, 1'b0, TMO - 1, 32'h13579BDF, -1);
    idle(1);
    // flush while BUSY: completion and timeout both produce nothing
    mem_op(32'h600, 32'h0, 5'd18, 1'b1, 1'b1, 2'd2, 1'b0, 2, 32'hFFFF0000, 1);
    mem_op(32'h604, 32'h0, 5'd19, 1'b1, 1'b1, 2'd2, 1'b0, -1, 32'h0, 0);
    idle(1);
    // flush in the accept cycle: no request
    i_valid = 1; i_flush = 1; i_busC = 32'h700; i_memrd = 1; i_memwr = 0; i_size = 2'd2;
    @(negedge clk);
    chk("flush_accept_stall", 160'(o_stall), 160'(0));
    @(posedge clk); #1;
    // bubble carrying memory-op bits
    i_valid = 0; i_flush = 0; i_memrd = 0; i_memwr = 1;
    @(negedge clk);
    chk("bubble_stall", 160'(o_stall), 160'(0));
    @(posedge clk); #1;
    idle(2);

    // reset in the middle of an access
    i_valid = 1; i_flush = 0; i_busC = 32'h800; i_busB = 0; i_rd = 5'd20; i_regwr = 1;
    i_memrd = 1; i_memwr = 0; i_size = 2'd2; i_unsigned = 0;
    exp_req_q.push_back({1'b0, 32'h800, 4'hF, 32'h0});
    @(negedge clk);
    chk("rst_accept_stall", 160'(o_stall), 160'(1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_busy_req", 160'(dm_if.o_dm_req), 160'(1));
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("rst_mid_outputs", 160'({o_stall, dm_if.o_dm_req, dm_if.o_dm_we, dm_if.o_dm_addr,
        dm_if.o_dm_be, dm_if.o_dm_wdata, o_valid, o_busW, o_rd, o_regwr, o_exc_align,
        o_exc_bus, o_badaddr}), 160'(0));
    chk("rst_mid_state", 160'(dbg_state == ST_IDLE), 160'(1));
    i_valid = 0; i_memrd = 0;
    #3;
    rst_n = 1;
    @(posedge clk); #1;
    alu_op(32'hFEEDFACE, 5'd21, 1'b0);
    idle(3);

    chk("exp_drained", 160'(exp_q.size()), 160'(0));
    chk("req_drained", 160'(exp_req_q.size()), 160'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
